// File: rtl/image_mem_reader.sv
// Streams a burst of image memory words to a valid/ready consumer; IMAGE_MEM_READER_WRAP_EN allows address wrap.
// Latency: first mem_re one cycle after start, first out_valid three cycles after start.
// Backpressure: reads are throttled so that reads in flight plus buffered words never exceed the 2-entry FIFO.

module image_mem_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    output logic                         pop_vld,
    input  logic                         pop_rdy,
    output logic [WIDTH-1:0]             pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // The caller guarantees no push while full, so there is no push_rdy.
    assign pop_vld = (count_q != '0);
    assign do_pop  = pop_vld && pop_rdy;
    assign do_push = push_vld;
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module image_mem_reader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rd_left_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_zero_q;
    logic              err_q;

    logic              range_ok;
    logic              start_ok;
    logic              accept;
    logic              pop;
    logic              last_issue;
    logic              last_pop;
    logic [1:0]        fifo_count;
    logic              fifo_vld;
    logic [DATA_W:0]   fifo_dat;

`ifdef IMAGE_MEM_READER_WRAP_EN
    assign range_ok = 1'b1;
`else
    logic [ADDR_W+1:0] end_addr;
    assign end_addr = (ADDR_W+2)'(base_addr) + (ADDR_W+2)'(length);
    assign range_ok = (end_addr <= (ADDR_W+2)'(2**ADDR_W));
`endif

    assign start_ok   = (state_q == IDLE) && start && (length != '0);
    assign accept     = start_ok && range_ok;
    assign pop        = out_valid && out_ready;
    // Words already buffered or in flight, minus the one leaving now, must stay below FIFO depth.
    assign mem_re     = (state_q == RUN) &&
                        (({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    assign last_issue = mem_re && (rd_left_q == (ADDR_W+1)'(1));
    assign last_pop   = pop && out_last;

    assign mem_raddr  = addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_zero_q || ((state_q == DRAIN) && last_pop);
    assign err        = err_q;
    assign out_valid  = fifo_vld;
    assign out_data   = fifo_dat[DATA_W-1:0];
    assign out_last   = fifo_vld && fifo_dat[DATA_W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (last_pop)   state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rd_left_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_zero_q     <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= mem_re;
            inflight_last_q <= last_issue;
            done_zero_q     <= (state_q == IDLE) && start && (length == '0);
            err_q           <= start_ok && !range_ok;
            if (accept) begin
                addr_q    <= base_addr;
                rd_left_q <= length;
            end else if (mem_re) begin
                addr_q    <= addr_q + ADDR_W'(1);
                rd_left_q <= rd_left_q - (ADDR_W+1)'(1);
            end
        end
    end

    // The last flag travels with the data so out_last needs no index compare at the output.
    image_mem_reader_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (inflight_q),
        .push_dat ({inflight_last_q, mem_rdata}),
        .pop_vld  (fifo_vld),
        .pop_rdy  (out_ready),
        .pop_dat  (fifo_dat),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_image_mem_reader.sv
// Directed bench for image_mem_reader: timing, backpressure, zero length, range/wrap, reset abort, busy start.
module tb_image_mem_reader;
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [12:0]   base_addr;
    logic [13:0]   length;
    logic          busy, done, err, mem_re;
    logic [12:0]   mem_raddr;
    logic [1023:0] mem_rdata;
    logic          out_valid, out_ready, out_last;
    logic [1023:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    image_mem_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [1023:0] word_of(input logic [12:0] a);
        logic [1023:0] w;
        for (int k = 0; k < 32; k++) begin
            w[32*k +: 32] = {3'b000, a, 11'(k), 5'h15};
        end
        return w;
    endfunction

    // Memory model: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        mem_rdata <= mem_re ? word_of(mem_raddr) : {32{32'hDEADBEEF}};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    // Runs one burst; mode 0 = out_ready high, mode 1 = out_ready 1,0,1,0...
    // A start with another base/length is pulsed at poke_cycle while busy.
    task automatic burst(input logic [12:0] b, input logic [13:0] n, input int mode, input int poke_cycle);
        int            issued = 0;
        int            acc    = 0;
        bit            fin    = 1'b0;
        bit            stalled = 1'b0;
        logic [1023:0] held;
        logic          held_last;
        logic          pop;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = n; out_ready = 1'b1;
        #1;
        chk("c0_mem_re", mem_re, 0);
        chk("c0_busy", busy, 0);
        for (int c = 1; c < 400 && !fin; c++) begin
            @(negedge clk);
            start     = (c == poke_cycle);
            base_addr = start ? (b ^ 13'h0c0) : b;
            length    = start ? 14'd3 : n;
            out_ready = (mode == 0) ? 1'b1 : (c % 2 == 0);
            #1;
            pop = out_valid && out_ready;
            chk("busy", busy, 1);
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chkw("stall_data", out_data, held);
                chk("stall_last", out_last, held_last);
            end
            if (mem_re) begin
                chk("raddr", mem_raddr, 32'(13'(b + issued)));
                chk("outstanding", 32'((issued - acc - int'(pop)) < 2), 1);
                chk("extra_read", 32'(issued < int'(n)), 1);
                issued++;
            end
            if (pop) begin
                chkw("data", out_data, word_of(13'(b + acc)));
                chk("last", out_last, 32'(acc == int'(n) - 1));
                chk("done_at_last", done, 32'(acc == int'(n) - 1));
                acc++;
                if (acc == int'(n)) fin = 1'b1;
            end else begin
                chk("done_idle", done, 0);
            end
            stalled   = out_valid && !out_ready;
            held      = out_data;
            held_last = out_last;
        end
        chk("burst_words", acc, 32'(n));
        chk("burst_reads", issued, 32'(n));
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        #1;
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_raddr", mem_raddr, 0);
        chkw("rst_out_data", out_data, '0);

        // Exact timing: base 0x10, length 4, no backpressure.
        @(negedge clk);
        start = 1'b1; base_addr = 13'h0010; length = 14'd4; out_ready = 1'b1;
        #1;
        chk("t35_c0_mem_re", mem_re, 0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk($sformatf("t35_c%0d_mem_re", c), mem_re, 32'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk($sformatf("t35_c%0d_raddr", c), mem_raddr, 32'(16 + c - 1));
            chk($sformatf("t35_c%0d_valid", c), out_valid, 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chkw($sformatf("t35_c%0d_data", c), out_data, word_of(13'(16 + c - 3)));
            chk($sformatf("t35_c%0d_last", c), out_last, 32'(c == 6));
            chk($sformatf("t35_c%0d_done", c), done, 32'(c == 6));
            chk($sformatf("t35_c%0d_busy", c), busy, 32'(c <= 6));
        end

        // Toggling backpressure.
        burst(13'h0100, 14'd8, 1, -1);

        // Zero length.
        @(negedge clk);
        start = 1'b1; base_addr = 13'h0005; length = 14'd0;
        #1;
        chk("len0_c0_mem_re", mem_re, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("len0_c1_done", done, 1);
        chk("len0_c1_busy", busy, 0);
        chk("len0_c1_mem_re", mem_re, 0);
        @(negedge clk);
        #1;
        chk("len0_c2_done", done, 0);
        chk("len0_c2_busy", busy, 0);

`ifdef IMAGE_MEM_READER_WRAP_EN
        burst(13'd8190, 14'd4, 0, -1);
`else
        @(negedge clk);
        start = 1'b1; base_addr = 13'd8190; length = 14'd4;
        #1;
        chk("range_c0_err", err, 0);
        chk("range_c0_mem_re", mem_re, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("range_c1_err", err, 1);
        chk("range_c1_mem_re", mem_re, 0);
        chk("range_c1_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("range_c2_err", err, 0);
        chk("range_c2_mem_re", mem_re, 0);
        chk("range_c2_done", done, 0);
        // Ends exactly at the top of memory: accepted.
        burst(13'd8188, 14'd4, 0, -1);
`endif

        // Reset after the second handshake of a 6-word burst.
        @(negedge clk);
        start = 1'b1; base_addr = 13'h0200; length = 14'd6; out_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk($sformatf("rab_c%0d_valid", c), out_valid, 32'(c >= 3));
            if (c >= 3) chkw($sformatf("rab_c%0d_data", c), out_data, word_of(13'(32'h200 + c - 3)));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rab_busy", busy, 0);
        chk("rab_done", done, 0);
        chk("rab_err", err, 0);
        chk("rab_mem_re", mem_re, 0);
        chk("rab_valid", out_valid, 0);
        chk("rab_last", out_last, 0);
        chk("rab_raddr", mem_raddr, 0);
        chkw("rab_data", out_data, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rab_after_valid", out_valid, 0);
            chk("rab_after_done", done, 0);
        end
        burst(13'h0300, 14'd2, 0, -1);

        // Start while busy is ignored.
        burst(13'h0040, 14'd5, 0, 2);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; base_addr = 13'h0000; length = 14'd4;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("rprio_busy", busy, 0);
        chk("rprio_mem_re", mem_re, 0);
        @(negedge clk);
        #1;
        chk("rprio_mem_re2", mem_re, 0);
        chk("rprio_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/image_mem_reader.md
IMAGE_MEM_READER -- requirements
Module: image_mem_reader

Interface
REQ-001 Parameter: ADDR_W, 13, memory address width (8192 words).
REQ-002 Parameter: DATA_W, 1024, memory word width (4x4 complex, 32-bit real/imag).
REQ-003 Port: clk  in  1  single clock, all logic on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: start  in  1  begin a read burst; sampled only in IDLE.
REQ-006 Port: base_addr  in  ADDR_W  first word address, latched on start.
REQ-007 Port: length  in  ADDR_W+1  word count 0..8192, latched on start.
REQ-008 Port: busy  out  1  burst in progress.
REQ-009 Port: done  out  1  one-cycle pulse at burst completion.
REQ-010 Port: err  out  1  one-cycle pulse on rejected start.
REQ-011 Port: mem_re  out  1  read enable to image memory block.
REQ-012 Port: mem_raddr  out  ADDR_W  read address to image memory block.
REQ-013 Port: mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re; element (i,j) real at bits 256i+64j+31:256i+64j, imag at +63:+32.
REQ-014 Port: out_valid  out  1  out_data valid.
REQ-015 Port: out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
REQ-016 Port: out_data  out  DATA_W  word, bit layout identical to mem_rdata.
REQ-017 Port: out_last  out  1  high with the final word of a burst.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start with length>0 and accepted range.
REQ-019 Start with length=0: no mem_re, done pulses the cycle after start, stays IDLE.
REQ-020 RUN issues reads base, base+1, ... ; RUN->DRAIN after the length-th mem_re; DRAIN->IDLE on handshake of the out_last word, done pulses in that same cycle.
REQ-021 First mem_re asserted the cycle after start is sampled; first out_valid 3 cycles after start cycle given no backpressure.
REQ-022 Output buffered by a 2-entry FIFO; rdata written into FIFO at the edge ending the cycle it is valid.
REQ-023 mem_re asserted only when fifo_count + inflight - pop < 2, where pop = out_valid && out_ready; no word ever dropped or duplicated.
REQ-024 With out_ready held high, sustained throughput is one word per cycle.
REQ-025 out_valid, out_data, out_last held stable while out_valid && !out_ready.
REQ-026 out_last asserted only on the word whose index is length-1.
REQ-027 busy high from the cycle after an accepted start through the done cycle inclusive.
REQ-028 start asserted while busy is ignored (no effect on parameters or state).
REQ-029 mem_raddr is don't-care when mem_re is low; mem_re never asserted in IDLE.

Reset
REQ-030 On rst: state IDLE, FIFO emptied, inflight cleared, busy/done/err/mem_re/out_valid/out_last = 0, out_data and mem_raddr = 0.
REQ-031 rst mid-burst aborts: no done pulse, rdata returning the cycle after rst is discarded.
REQ-032 rst takes priority over start in the same cycle.

Configuration
REQ-033 Macro IMAGE_MEM_READER_WRAP_EN: defined -> address wraps 8191->0, any base/length accepted.
REQ-034 Undefined -> start with base_addr+length > 8192 is rejected: err pulses next cycle, no reads, stays IDLE.

Verification
REQ-035 base=0x0010, length=4, out_ready=1 -> mem_re cycles 1-4, addresses 0x10-0x13, out_valid cycles 3-6, out_last and done in cycle 6.
REQ-036 length=8, out_ready toggles 1,0 each cycle -> 8 words in order, never >2 reads outstanding+buffered, out_data stable while stalled.
REQ-037 length=0 -> no mem_re, done pulse cycle 1, busy never high.
REQ-038 base=8190, length=4 -> WRAP_EN: addresses 8190,8191,0,1; without: err pulse cycle 1, no mem_re.
REQ-039 rst asserted after 2nd handshake of length=6 burst -> all outputs 0 next cycle, no done, new start then runs cleanly.
REQ-040 start pulsed while busy with different base -> ignored, original burst completes unchanged.
